alu_logic_pipe: RTL and testbench
=================================

Name: alu_logic_pipe

Overview:
Two-stage pipelined 32-bit logic execution unit with valid/ready handshakes on the operand side and the result side. It accepts an operand pair plus a 2-bit logic opcode from the decode/issue stage and returns the result, a zero flag and a tag to writeback. It handles backpressure without dropping or duplicating results, and keeps a free-running completed-operation counter for debug.

Parameters:
WIDTH, 32, operand/result width in bits
TAGW, 5, width of the destination tag carried alongside each operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  unit can accept a request this cycle
op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
a  input  WIDTH  operand A
b  input  WIDTH  operand B
in_tag  input  TAGW  destination tag
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  logic result
zero  output  1  result == 0
out_tag  output  TAGW  tag of the returned result
op_count  output  32  number of completed output handshakes

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=0, out_tag=0, op_count=0. in_ready reads 1 one clock after rst_n deasserts; while in reset it is 0.
- Stage 1 (S1) registers op/a/b/in_tag. Stage 2 (S2) registers the computed result, zero and tag. Outputs are driven directly from S2 registers; there is no combinational path from a/b to result.
- Handshake: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- s2_free = !s2_valid || out_ready.
- s1_adv = s1_valid && s2_free.
- in_ready = !s1_valid || s2_free. Combinational from out_ready only; never from in_valid.
- Latency: a request accepted in cycle N has out_valid=1 in cycle N+2 if no backpressure occurs. Throughput is 1 op/cycle with out_ready held high.
- Compute on s1_adv: AND a&b, OR a|b, XOR a^b, NOR ~(a|b), all full-width. zero = (computed == 0).
- When s1_adv=0 and an output transfer occurs, s2_valid clears. result/zero/out_tag hold their last values (not cleared).
- When out_valid=1 and out_ready=0, result/zero/out_tag are stable until the transfer.
- Full condition: S1 and S2 both valid and out_ready=0 give in_ready=0. Exactly 2 ops are held; none are lost.
- Empty: in_ready=1, out_valid=0.
- Simultaneous input and output transfer in one cycle: both occur, and the pipeline occupancy is unchanged.
- op_count increments by 1 on each output transfer and wraps from 0xFFFFFFFF to 0.
- rst_n asserted mid-operation discards all in-flight ops immediately. There is no partial output.
- a, b, op and in_tag are don't-care when in_valid=0. Holding in_valid high without a handshake is legal, and the request may change before acceptance.

Test Plan:
- Reset then single op: op=00, a=0xF0F0_1234, b=0xFF00_FF00, tag=3, out_ready=1. Expect result=0xF000_1200, zero=0, out_tag=3, out_valid exactly 2 cycles after acceptance, op_count=1.
- All opcodes back-to-back: a=0x0000_FFFF, b=0x00FF_00FF, ops 00/01/10/11 on consecutive cycles. Expect 0x0000_00FF, 0x00FF_FFFF, 0x00FF_FF00, 0xFF00_0000 on 4 consecutive cycles.
- Zero flag: op=11 with a=0xFFFF_FFFF, b=0 gives result=0, zero=1. op=00 with a=0xAAAA_AAAA, b=0x5555_5555 gives zero=1.
- Backpressure: stream 6 ops with tags 0..5 while out_ready=0 for cycles 3–8. Expect in_ready=0 once 2 ops are held, stable outputs during the stall, all 6 results in order, none duplicated, op_count=6.
- Random stall: random in_valid/out_ready over 10k ops. Compare against a scoreboard model. Check in_ready never depends on in_valid.
- Wrap and reset: force op_count to 0xFFFF_FFFF and complete 1 op, expect 0. Assert rst_n low with 2 ops in flight, expect out_valid=0 immediately and no result emitted after release.

Source files
------------

// File: rtl/alu_logic_pipe_if.sv
// alu_logic_pipe_if: operand request and result response channels of the logic pipe
interface alu_logic_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, op, a, b, in_tag, out_ready,
        input  in_ready, out_valid, result, zero, out_tag
    );

    modport slave (
        input  in_valid, op, a, b, in_tag, out_ready,
        output in_ready, out_valid, result, zero, out_tag
    );
endinterface

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe: two-stage AND/OR/XOR/NOR unit with valid/ready on both sides
module alu_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_logic_pipe_if.slave io,
    output logic [31:0] op_count
);
    logic             live;
    logic             s1_valid, s2_valid, s2_zero;
    logic [1:0]       s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, s2_res, comp;
    logic [TAGW-1:0]  s1_tag, s2_tag;
    logic [31:0]      cnt;
    logic             s2_free, s1_adv, s1_load, out_fire;

    // live holds in_ready low until the first clock after reset release
    always_comb begin
        s2_free  = !s2_valid || io.out_ready;
        s1_adv   = s1_valid && s2_free;
        s1_load  = live && (!s1_valid || s2_free);
        out_fire = s2_valid && io.out_ready;
        comp     = s1_op == 2'b00 ? s1_a & s1_b :
                   s1_op == 2'b01 ? s1_a | s1_b :
                   s1_op == 2'b10 ? s1_a ^ s1_b : ~(s1_a | s1_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live     <= 1'b0;
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else begin
            live <= 1'b1;
            if (s1_load) s1_valid <= io.in_valid;
            if (s1_load && io.in_valid) begin
                s1_op  <= io.op;
                s1_a   <= io.a;
                s1_b   <= io.b;
                s1_tag <= io.in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_zero  <= 1'b0;
            s2_tag   <= '0;
            cnt      <= '0;
        end else begin
            if (s2_free) s2_valid <= s1_valid;
            if (s1_adv) begin
                s2_res  <= comp;
                s2_zero <= comp == '0;
                s2_tag  <= s1_tag;
            end
            if (out_fire) cnt <= cnt + 32'd1;
        end
    end

    assign io.in_ready  = s1_load;
    assign io.out_valid = s2_valid;
    assign io.result    = s2_res;
    assign io.zero      = s2_zero;
    assign io.out_tag   = s2_tag;
    assign op_count     = cnt;
endmodule

// File: tb/tb_alu_logic_pipe.sv
// tb_alu_logic_pipe: directed and random traffic against a result scoreboard
module tb_alu_logic_pipe;
    localparam int W = 32;
    localparam int T = 5;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic [T-1:0] t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op_count;
    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          run = 0;
    int          max_run = 0;
    bit          done = 1'b0;

    always #5 clk = ~clk;

    alu_logic_pipe_if #(.WIDTH(W), .TAGW(T)) bus ();
    alu_logic_pipe #(.WIDTH(W), .TAGW(T)) dut (.clk(clk), .rst_n(rst_n), .io(bus), .op_count(op_count));

    function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [T-1:0] t, input logic [W-1:0] er);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.in_tag = t;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 500) begin
                $display("FAIL issue_timeout: got no in_ready expected in_ready within 500 cycles");
                $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
                $fatal(1, "issue timeout");
            end
            @(posedge clk);
            #1;
        end
        sb.push_back('{r: er, z: (er == '0), t: t});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic indep_check();
        logic r1, r0;
        bus.in_valid = 1'b1;
        #2;
        r1 = bus.in_ready;
        bus.in_valid = 1'b0;
        #1;
        r0 = bus.in_ready;
        chk("in_ready_vs_in_valid", r0, r1);
    endtask

    initial begin
        logic pv = 1'b0;
        exp_t prev, e;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 1'b0;
            if (pv) begin
                chk("stall_valid", bus.out_valid, 1'b1);
                chk("stall_data", {bus.result, bus.zero, bus.out_tag}, prev);
            end
            pv = bus.out_valid && !bus.out_ready;
            prev = '{r: bus.result, z: bus.zero, t: bus.out_tag};
            if (bus.out_valid && bus.out_ready) begin
                run++;
                if (run > max_run) max_run = run;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got tag %0d result %0h expected no output", bus.out_tag, bus.result);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.r);
                    chk("zero", bus.zero, e.z);
                    chk("tag", bus.out_tag, e.t);
                end
            end else run = 0;
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1'b0);
        chk("rst_tag", bus.out_tag, 0);
        chk("rst_count", op_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_clock", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_clock", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // single op and latency
        issue(2'b00, 32'hF0F0_1234, 32'hFF00_FF00, 5'd3, 32'hF000_1200);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("latency_n1", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("latency_n2", bus.out_valid, 1'b1);
        @(posedge clk);
        #1;
        idle(3);
        chk("count_single", op_count, 1);

        // all opcodes back-to-back
        max_run = 0;
        issue(2'b00, 32'h0000_FFFF, 32'h00FF_00FF, 5'd4, 32'h0000_00FF);
        issue(2'b01, 32'h0000_FFFF, 32'h00FF_00FF, 5'd5, 32'h00FF_FFFF);
        issue(2'b10, 32'h0000_FFFF, 32'h00FF_00FF, 5'd6, 32'h00FF_FF00);
        issue(2'b11, 32'h0000_FFFF, 32'h00FF_00FF, 5'd7, 32'hFF00_0000);
        idle(5);
        chk("back_to_back_run", max_run >= 4, 1'b1);
        chk("count_ops", op_count, 5);

        // zero flag
        issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 5'd8, 32'h0);
        issue(2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 5'd9, 32'h0);
        idle(5);
        chk("count_zero", op_count, 7);

        // backpressure stall
        fork
            begin
                for (int t = 0; t < 6; t++)
                    issue(2'b10, 32'h0101_0101 * t, 32'h0F0F_0F0F, T'(t), (32'h0101_0101 * t) ^ 32'h0F0F_0F0F);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("full_in_ready", bus.in_ready, 1'b0);
                chk("full_out_valid", bus.out_valid, 1'b1);
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(8);
        chk("stall_drained", sb.size(), 0);
        chk("count_stall", op_count, 13);

        // random traffic
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [1:0] o;
                    logic [W-1:0] x, y;
                    o = 2'($urandom);
                    x = $urandom;
                    y = ($urandom_range(0, 7) == 0) ? ~x : $urandom;
                    if ($urandom_range(0, 3) == 0) idle(1);
                    if ($urandom_range(0, 31) == 0) indep_check();
                    issue(o, x, y, T'($urandom), ref_op(o, x, y));
                end
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            while (!done) begin
                @(posedge clk);
                #2 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus.out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        chk("random_drained", sb.size(), 0);
        chk("count_random", op_count, 10013);

        // counter wrap
        force dut.cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt;
        @(posedge clk);
        #1;
        issue(2'b01, 32'h1234_0000, 32'h0000_5678, 5'd1, 32'h1234_5678);
        idle(4);
        chk("count_wrap", op_count, 0);

        // reset with two ops in flight
        bus.out_ready = 1'b0;
        issue(2'b00, 32'hFFFF_FFFF, 32'h1111_1111, 5'd10, 32'h1111_1111);
        issue(2'b01, 32'h0, 32'h2222_2222, 5'd11, 32'h2222_2222);
        idle(2);
        chk("held_out_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 1'b0);
        chk("async_in_ready", bus.in_ready, 1'b0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_out_valid", bus.out_valid, 1'b0);
        chk("post_reset_count", op_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
